// File: rtl/io_cfg_seq.sv
// Pin-mux configuration sequencer: shadow bank with code/resource validation and
// break-before-make commit of changed pins into the active config driving io_map.
module io_cfg_seq #(
  parameter int PIN_NUM   = 16,
  parameter int CFG_NBIT  = 8,
  parameter int ADDR_NBIT = 4,
  parameter int GUARD_CYC = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         i_wr_en,
  input  logic [ADDR_NBIT-1:0]         i_wr_addr,
  input  logic [CFG_NBIT-1:0]          i_wr_data,
  input  logic                         i_apply,
  output logic                         o_busy,
  output logic                         o_done,
  output logic [1:0]                   o_err_code,
  output logic [PIN_NUM*CFG_NBIT-1:0]  o_cfg,
  output logic [PIN_NUM-1:0]           o_park
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CHECK,
    S_PARK,
    S_COMMIT,
    S_SETTLE,
    S_DONE
  } state_t;

  localparam logic [1:0] ERR_NONE     = 2'd0;
  localparam logic [1:0] ERR_BAD_WR   = 2'd1;
  localparam logic [1:0] ERR_BUSY     = 2'd2;
  localparam logic [1:0] ERR_CONFLICT = 2'd3;
  localparam logic [7:0] GUARD_LOAD   = 8'(GUARD_CYC - 1);

  state_t                             state_q, state_d;
  logic [PIN_NUM-1:0][CFG_NBIT-1:0]   shadow_q, shadow_d;
  logic [PIN_NUM-1:0][CFG_NBIT-1:0]   active_q, active_d;
  logic [PIN_NUM-1:0]                 chg_q, chg_d;
  logic [PIN_NUM-1:0]                 park_q, park_d;
  logic [7:0]                         cnt_q, cnt_d;
  logic                               busy_q, busy_d;
  logic                               done_q, done_d;
  logic [1:0]                         err_q, err_d;

  logic [PIN_NUM-1:0]                 changed;
  logic                               conflict;
  logic                               wr_bad;

  function automatic logic code_valid(input logic [CFG_NBIT-1:0] c);
    return (c <= CFG_NBIT'(8'h08)) || (c == CFG_NBIT'(8'h19)) ||
           (c == CFG_NBIT'(8'h20)) || (c == CFG_NBIT'(8'h21)) ||
           (c == CFG_NBIT'(8'h22));
  endfunction

  // SDA and counter codes name a single physical resource; clock codes may fan out.
  function automatic logic code_exclusive(input logic [CFG_NBIT-1:0] c);
    return ((c >= CFG_NBIT'(8'h05)) && (c <= CFG_NBIT'(8'h08))) ||
           (c == CFG_NBIT'(8'h19)) || (c == CFG_NBIT'(8'h20)) ||
           (c == CFG_NBIT'(8'h21)) || (c == CFG_NBIT'(8'h22));
  endfunction

  assign wr_bad = !code_valid(i_wr_data) || (32'(i_wr_addr) >= PIN_NUM);

  always_comb begin
    changed  = '0;
    conflict = 1'b0;
    for (int i = 0; i < PIN_NUM; i++) begin
      changed[i] = (shadow_q[i] != active_q[i]);
      for (int j = i + 1; j < PIN_NUM; j++) begin
        if (code_exclusive(shadow_q[i]) && (shadow_q[i] == shadow_q[j])) conflict = 1'b1;
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    shadow_d = shadow_q;
    active_d = active_q;
    chg_d    = chg_q;
    park_d   = park_q;
    cnt_d    = cnt_q;
    done_d   = 1'b0;
    err_d    = err_q;

    if ((state_q != S_IDLE) && (i_wr_en || i_apply)) err_d = ERR_BUSY;

    case (state_q)
      S_IDLE: begin
        if (i_apply) begin
          err_d   = ERR_NONE;
          state_d = S_CHECK;
        end
        // The write lands before CHECK, and its error wins over the apply's clear.
        if (i_wr_en) begin
          if (wr_bad) err_d = ERR_BAD_WR;
          else        shadow_d[i_wr_addr] = i_wr_data;
        end
      end
      S_CHECK: begin
        chg_d = changed;
        if (conflict) begin
          err_d   = ERR_CONFLICT;
          state_d = S_DONE;
          done_d  = 1'b1;
        end else if (changed == '0) begin
          state_d = S_DONE;
          done_d  = 1'b1;
        end else begin
          state_d = S_PARK;
          park_d  = changed;
          cnt_d   = GUARD_LOAD;
        end
      end
      S_PARK: begin
        if (cnt_q == 8'd0) begin
          state_d = S_COMMIT;
          for (int m = 0; m < PIN_NUM; m++) begin
            if (chg_q[m]) active_d[m] = shadow_q[m];
          end
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      S_COMMIT: begin
        state_d = S_SETTLE;
        cnt_d   = GUARD_LOAD;
      end
      S_SETTLE: begin
        if (cnt_q == 8'd0) begin
          state_d = S_DONE;
          park_d  = '0;
          done_d  = 1'b1;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      shadow_q <= '0;
      active_q <= '0;
      chg_q    <= '0;
      park_q   <= '0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= ERR_NONE;
    end else begin
      state_q  <= state_d;
      shadow_q <= shadow_d;
      active_q <= active_d;
      chg_q    <= chg_d;
      park_q   <= park_d;
      cnt_q    <= cnt_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

  // Pin 0 sits in the most significant slice of the io_map config bus.
  always_comb begin
    o_cfg = '0;
    for (int m = 0; m < PIN_NUM; m++) begin
      o_cfg[(PIN_NUM-1-m)*CFG_NBIT +: CFG_NBIT] = active_q[m];
    end
  end

  assign o_busy     = busy_q;
  assign o_done     = done_q;
  assign o_err_code = err_q;
  assign o_park     = park_q;

endmodule

// File: tb/tb_io_cfg_seq.sv
// Bench for io_cfg_seq: write-validation table plus scoreboarded apply sequences
// covering break-before-make timing, conflicts, busy errors and mid-flight reset.
module tb_io_cfg_seq;

  localparam int G = 4;

  logic         clk;
  logic         rst;
  logic         i_wr_en;
  logic [3:0]   i_wr_addr;
  logic [7:0]   i_wr_data;
  logic         i_apply;
  logic         o_busy;
  logic         o_done;
  logic [1:0]   o_err_code;
  logic [127:0] o_cfg;
  logic [15:0]  o_park;

  io_cfg_seq #(.PIN_NUM(16), .CFG_NBIT(8), .ADDR_NBIT(4), .GUARD_CYC(G)) dut (
    .clk(clk), .rst(rst), .i_wr_en(i_wr_en), .i_wr_addr(i_wr_addr),
    .i_wr_data(i_wr_data), .i_apply(i_apply), .o_busy(o_busy), .o_done(o_done),
    .o_err_code(o_err_code), .o_cfg(o_cfg), .o_park(o_park)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] addr;
    logic [7:0] data;
    logic [1:0] exp_err;
  } wvec_t;

  typedef struct {
    int           apply_cyc;
    int           exp_lat;
    logic [15:0]  exp_park;
    logic [127:0] exp_cfg;
    logic [1:0]   exp_err;
    int           exp_chg_k;
  } exp_t;

  exp_t       sb_q[$];
  wvec_t      wtab[9];
  int         checks = 0;
  int         failures = 0;
  int         cyc = 0;
  int         done_seen = 0;
  logic [7:0] model_shadow[16];
  logic [7:0] model_active[16];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic logic tb_valid(input logic [7:0] d);
    return (d inside {[8'h00:8'h08], 8'h19, 8'h20, 8'h21, 8'h22});
  endfunction

  function automatic logic [127:0] pack_cfg();
    logic [127:0] v = '0;
    for (int m = 0; m < 16; m++) v[(16-m)*8-1 -: 8] = model_active[m];
    return v;
  endfunction

  initial begin
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  // Scoreboard monitor: tracks park mask and o_cfg changes per in-flight apply.
  initial begin
    int           park_bad;
    int           chg_cnt;
    int           chg_k;
    int           k;
    logic [127:0] prev_cfg;
    logic [15:0]  ep;
    exp_t         e;
    park_bad = 0; chg_cnt = 0; chg_k = -1; prev_cfg = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        park_bad = 0; chg_cnt = 0; chg_k = -1; prev_cfg = o_cfg;
      end else begin
        if (sb_q.size() > 0) begin
          k  = cyc - sb_q[0].apply_cyc;
          ep = (k >= 2 && k <= 2*G+2) ? sb_q[0].exp_park : 16'h0;
          if (o_park !== ep) park_bad++;
          if (o_cfg !== prev_cfg) begin
            chg_cnt++;
            chg_k = k;
          end
        end
        prev_cfg = o_cfg;
        if (o_done) begin
          done_seen++;
          if (sb_q.size() == 0) begin
            chk("unexpected_done", 1, 0);
          end else begin
            e = sb_q.pop_front();
            chk("done_latency", cyc - e.apply_cyc, e.exp_lat);
            chk("err_at_done", o_err_code, e.exp_err);
            chk("cfg_at_done", o_cfg, e.exp_cfg);
            chk("park_profile_bad_cycles", park_bad, 0);
            chk("cfg_change_count", chg_cnt, (e.exp_chg_k < 0) ? 0 : 1);
            chk("cfg_change_cycle", chg_k, e.exp_chg_k);
            park_bad = 0; chg_cnt = 0; chg_k = -1;
          end
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [3:0] a, input logic [7:0] d);
    i_wr_en = 1'b1; i_wr_addr = a; i_wr_data = d;
    if (tb_valid(d)) model_shadow[a] = d;
    step();
    i_wr_en = 1'b0;
  endtask

  task automatic push_exp(input int lat, input logic [15:0] park, input logic [1:0] err,
                          input logic commit);
    exp_t e;
    if (commit) for (int m = 0; m < 16; m++) model_active[m] = model_shadow[m];
    e.apply_cyc = cyc;
    e.exp_lat   = lat;
    e.exp_park  = park;
    e.exp_cfg   = pack_cfg();
    e.exp_err   = err;
    e.exp_chg_k = commit ? G + 2 : -1;
    sb_q.push_back(e);
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while ((sb_q.size() != 0 || o_busy) && n < 100) begin
      step();
      n++;
    end
    if (n >= 100) chk({name, "_timeout"}, 1, 0);
  endtask

  task automatic apply(input string name, input logic w, input logic [3:0] a,
                       input logic [7:0] d, input int lat, input logic [15:0] park,
                       input logic [1:0] err, input logic commit);
    i_apply = 1'b1;
    if (w) begin
      i_wr_en = 1'b1; i_wr_addr = a; i_wr_data = d;
      if (tb_valid(d)) model_shadow[a] = d;
    end
    push_exp(lat, park, err, commit);
    step();
    i_apply = 1'b0;
    i_wr_en = 1'b0;
    wait_idle(name);
  endtask

  initial begin
    int done_before;
    rst = 1'b1; i_wr_en = 1'b0; i_wr_addr = '0; i_wr_data = '0; i_apply = 1'b0;
    for (int m = 0; m < 16; m++) begin
      model_shadow[m] = 8'h00;
      model_active[m] = 8'h00;
    end
    wtab[0] = '{4'd3,  8'h05, 2'd0};
    wtab[1] = '{4'd10, 8'h22, 2'd0};
    wtab[2] = '{4'd1,  8'h1A, 2'd1};
    wtab[3] = '{4'd10, 8'h00, 2'd1};
    wtab[4] = '{4'd0,  8'h09, 2'd1};
    wtab[5] = '{4'd11, 8'h08, 2'd1};
    wtab[6] = '{4'd9,  8'h23, 2'd1};
    wtab[7] = '{4'd11, 8'h00, 2'd1};
    wtab[8] = '{4'd9,  8'h18, 2'd1};

    repeat (3) step();
    rst = 1'b0;
    step();
    chk("reset_cfg", o_cfg, 0);
    chk("reset_park", o_park, 0);
    chk("reset_err", o_err_code, 0);
    chk("reset_busy", o_busy, 0);
    chk("reset_done", o_done, 0);

    for (int i = 0; i < 9; i++) begin
      wr(wtab[i].addr, wtab[i].data);
      chk($sformatf("wr_err_%0d", i), o_err_code, wtab[i].exp_err);
      chk($sformatf("wr_busy_%0d", i), o_busy, 0);
    end

    apply("pin3_sda", 1'b0, 4'd0, 8'h00, 2*G+3, 16'h0008, 2'd0, 1'b1);
    apply("no_change", 1'b0, 4'd0, 8'h00, 2, 16'h0000, 2'd0, 1'b0);

    wr(4'd0, 8'h19);
    wr(4'd7, 8'h19);
    apply("ctr_conflict", 1'b0, 4'd0, 8'h00, 2, 16'h0000, 2'd3, 1'b0);
    wr(4'd0, 8'h00);
    wr(4'd7, 8'h00);
    chk("err_sticky_after_conflict", o_err_code, 3);

    apply("wr_with_apply", 1'b1, 4'd4, 8'h02, 2*G+3, 16'h0010, 2'd0, 1'b1);

    wr(4'd2, 8'h01);
    wr(4'd5, 8'h01);
    apply("shared_clock", 1'b0, 4'd0, 8'h00, 2*G+3, 16'h0024, 2'd0, 1'b1);

    wr(4'd6, 8'h06);
    wr(4'd8, 8'h06);
    apply("sda_conflict", 1'b0, 4'd0, 8'h00, 2, 16'h0000, 2'd3, 1'b0);
    wr(4'd8, 8'h00);
    apply("pin6_sda", 1'b0, 4'd0, 8'h00, 2*G+3, 16'h0040, 2'd0, 1'b1);

    // Write and apply arriving during PARK must be dropped with a busy error.
    wr(4'd12, 8'h03);
    i_apply = 1'b1;
    push_exp(2*G+3, 16'h1000, 2'd2, 1'b1);
    step();
    i_apply = 1'b0;
    step();
    step();
    i_wr_en = 1'b1; i_wr_addr = 4'd12; i_wr_data = 8'h07;
    step();
    i_wr_en = 1'b0; i_apply = 1'b1;
    step();
    i_apply = 1'b0;
    chk("busy_err_midflight", o_err_code, 2);
    wait_idle("busy_ignore");
    apply("shadow_kept", 1'b0, 4'd0, 8'h00, 2, 16'h0000, 2'd0, 1'b0);

    // Reset during SETTLE: no scoreboard entry since no o_done may follow.
    wr(4'd13, 8'h04);
    i_apply = 1'b1;
    step();
    i_apply = 1'b0;
    repeat (7) step();
    chk("settle_busy", o_busy, 1);
    chk("settle_park", o_park, 16'h2000);
    chk("settle_cfg_pin13", o_cfg[(16-13)*8-1 -: 8], 8'h04);
    rst = 1'b1;
    #1;
    chk("rst_cfg", o_cfg, 0);
    chk("rst_park", o_park, 0);
    chk("rst_busy", o_busy, 0);
    chk("rst_done", o_done, 0);
    chk("rst_err", o_err_code, 0);
    for (int m = 0; m < 16; m++) begin
      model_shadow[m] = 8'h00;
      model_active[m] = 8'h00;
    end
    step();
    step();
    rst = 1'b0;
    done_before = done_seen;
    repeat (20) step();
    chk("no_done_after_rst", done_seen - done_before, 0);
    chk("post_rst_busy", o_busy, 0);
    chk("post_rst_cfg", o_cfg, 0);
    apply("post_rst_shadow_clear", 1'b0, 4'd0, 8'h00, 2, 16'h0000, 2'd0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/io_cfg_seq.md
# io_cfg_seq

Configuration sequencer for the pin mux: owns the per-pin configuration vector that drives `io_map` `i_cfg`. Accepts per-pin writes from the USB command decoder into a shadow bank, validates codes, and checks MIPI-SDA and counter resource conflicts. On an apply command it commits changes break-before-make: changed pins are parked as inputs for a guard interval before and after the switch.

## Interface
- PIN_NUM, 16, number of mapped pins (equals `IO_UNIT_NBIT`)
- CFG_NBIT, 8, config code width (equals `IOCFG_DATA_NBIT`)
- ADDR_NBIT, 4, pin address width
- GUARD_CYC, 4, park cycles before and after commit (range 1..255)

- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-high
- i_wr_en  in  1  shadow write strobe, one cycle per write
- i_wr_addr  in  ADDR_NBIT  pin index
- i_wr_data  in  CFG_NBIT  config code
- i_apply  in  1  commit request, single-cycle pulse
- o_busy  out  1  high in every state except IDLE
- o_done  out  1  one-cycle pulse at end of every accepted apply
- o_err_code  out  2  0 none, 1 bad write, 2 request while busy, 3 resource conflict
- o_cfg  out  PIN_NUM*CFG_NBIT  active config to `io_map`; pin m at bits [(PIN_NUM-m)*CFG_NBIT-1 : (PIN_NUM-m-1)*CFG_NBIT]
- o_park  out  PIN_NUM  per-pin force-input mask; ANDed low onto `o_io_dir` downstream

## Operation
- Valid codes: 0x00–0x08, 0x19, 0x20, 0x21, 0x22. Any other code is bad. Any address >= PIN_NUM is bad.
- A valid write in IDLE updates `shadow[addr]`. A bad write is dropped and sets o_err_code=1. Any write while busy is dropped and sets o_err_code=2.
- i_apply in IDLE is accepted: o_err_code is cleared to 0, then the state goes to CHECK. i_apply while busy is ignored and sets o_err_code=2.
- A write and i_apply in the same IDLE cycle: the write lands first and CHECK sees it. An error from that write overrides the clear.
- CHECK (1 cycle):
  - changed = per-pin (shadow != active).
  - conflict = any SDA code (0x05–0x08) or counter code (0x19/0x20/0x21/0x22) held by more than one pin in shadow. Clock codes 0x01–0x04 may be shared.
  - conflict: o_err_code=3, go to DONE, active is untouched.
  - changed==0: go to DONE.
  - otherwise go to PARK.
- PARK (GUARD_CYC cycles): o_park=changed; o_cfg still shows the old active values.
- COMMIT (1 cycle): active[m] <= shadow[m] for changed pins; o_park is held.
- SETTLE (GUARD_CYC cycles): o_park is held; o_cfg shows the new values.
- DONE (1 cycle): o_park=0, o_done=1, then go to IDLE.
- o_park is registered. It goes 1 on entry to PARK and 0 on entry to DONE. Unchanged pins are never parked and their o_cfg never glitches.

## Timing
- Reset values: state IDLE, shadow all 0, active all 0, o_cfg all 0 (every pin GPIO), o_park 0, o_busy 0, o_done 0, o_err_code 0.
- All outputs are registered; o_cfg is taken directly from the active register.
- i_apply is sampled at cycle 0:
  - o_busy=1 from cycle 1.
  - Normal apply: o_done=1 in cycle 2*GUARD_CYC+3; o_busy=0 from cycle 2*GUARD_CYC+4.
  - No-change or conflict apply: o_done=1 in cycle 2.
- o_cfg changes exactly once per apply, in cycle GUARD_CYC+2.
- Guard counter is 8 bits, loaded with GUARD_CYC-1 on entry and decremented to 0; no wrap.
- Reset asserted mid-operation: everything returns to reset values immediately, including o_cfg=0 and o_park=0; no o_done pulse.

## Test plan
- Reset then idle: o_cfg=0, o_park=0, o_err_code=0. Write pin3=0x05 and apply with GUARD_CYC=4 -> o_park=16'h0008 in cycles 2–10, o_cfg pin3 becomes 0x05 in cycle 6, o_done in cycle 11.
- Write pin0=0x19 and pin7=0x19, then apply -> o_err_code=3, o_done in cycle 2, o_cfg unchanged, o_park never set.
- Write pin1=0x1A, then write addr 0x0 with code 0x09 -> both dropped, o_err_code=1, shadow unchanged. Re-apply with no pending changes -> o_done in cycle 2, o_err_code=0.
- Mid-sequence (state PARK): pulse i_wr_en and then i_apply -> both ignored, o_err_code=2. Sequence completes with the original values.
- Pins 2 and 5 both set to 0x01 (shared clock) -> accepted, o_park=16'h0024, both pins committed in the same cycle.
- Assert rst during SETTLE -> o_cfg=0, o_park=0, o_busy=0 immediately. No o_done pulse after rst is released.
